// File: rtl/clk_meas.sv
// Purpose: clock-period meter; counts fsys cycles between two rising edges of an async input and derives the divider select.
// Latency: input edge to internal rise pulse is SYNC_STAGES+1 cycles; results plus a one-cycle valid follow the closing rise by one cycle.
// Backpressure: none; start is honoured only in IDLE, and results hold until the next capture.
// Build option: define CLK_MEAS_CONT_EN for continuous mode; leave it undefined for single-shot mode.
module clk_meas #(
    parameter int SIZE        = 26,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    fsys,
    input  logic                    clk_meas_rst,
    input  logic                    clk_meas_in,
    input  logic                    clk_meas_start,
    output logic                    clk_meas_busy,
    output logic                    clk_meas_valid,
    output logic                    clk_meas_err,
    output logic [SIZE:0]           clk_meas_period,
    output logic [$clog2(SIZE)-1:0] clk_meas_s
);

    localparam int SW = $clog2(SIZE);
    localparam int MW = $clog2(SIZE + 1);

    // The count saturates at all-ones. The largest period that is still legal is 2^SIZE.
    localparam logic [SIZE:0] CNT_MAX = {(SIZE + 1){1'b1}};
    localparam logic [SIZE:0] CNT_ONE = {{SIZE{1'b0}}, 1'b1};
    localparam logic [SIZE:0] P_MAX   = {1'b1, {SIZE{1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                dly_q;
    logic [SIZE:0]       cnt_q, cnt_d;
    logic [SIZE:0]       period_q, period_d;
    logic [SW-1:0]       s_q, s_d;
    logic                err_q, err_d;
    logic                valid_q, valid_d;

    logic                rise;
    logic [MW-1:0]       msb;
    logic [SW-1:0]       log_s;
    logic                cnt_pow2;

    // Synchronizer chain plus one delay flop, used for rising-edge detection of the measured clock.
    always_ff @(posedge fsys or posedge clk_meas_rst) begin
        if (clk_meas_rst) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], clk_meas_in};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;

    // Find the index of the highest set bit of the count (floor log2). This gives s = log2(cnt) - 1.
    always_comb begin
        msb = '0;
        for (int i = 0; i <= SIZE; i++) begin
            if (cnt_q[i]) msb = MW'(i);
        end
    end

    assign log_s    = (msb == '0) ? '0 : SW'(msb - MW'(1));
    assign cnt_pow2 = (cnt_q != '0) && ((cnt_q & (cnt_q - CNT_ONE)) == '0);

    // State, counter and result registers.
    always_ff @(posedge fsys or posedge clk_meas_rst) begin
        if (clk_meas_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            s_q      <= '0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            s_q      <= s_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
        end
    end

    // Next-state logic: wait for start, arm on an edge, then count up to the closing edge or to saturation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        s_d      = s_q;
        err_d    = err_q;
        valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // An edge in the same cycle as start is ignored; only edges seen in ARM open a measurement.
                if (clk_meas_start) state_d = ARM;
            end
            ARM: begin
                if (rise) begin
                    cnt_d   = CNT_ONE;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (rise) begin
                    valid_d  = 1'b1;
                    period_d = cnt_q;
                    s_d      = log_s;
                    err_d    = ~cnt_pow2 || (cnt_q > P_MAX);
`ifdef CLK_MEAS_CONT_EN
                    // The closing edge also opens the next measurement.
                    cnt_d    = CNT_ONE;
`else
                    state_d  = IDLE;
`endif
                end else if (cnt_q == CNT_MAX) begin
                    // Timeout: no edge arrived before the counter saturated.
                    valid_d  = 1'b1;
                    period_d = CNT_MAX;
                    s_d      = '0;
                    err_d    = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign clk_meas_busy   = (state_q != IDLE);
    assign clk_meas_valid  = valid_q;
    assign clk_meas_err    = err_q;
    assign clk_meas_period = period_q;
    assign clk_meas_s      = s_q;

endmodule

// File: tb/tb_clk_meas.sv
// Purpose: self-checking bench for clk_meas; runs a SIZE=26 and a SIZE=4 instance side by side on the same stimulus.
// Latency: results are compared in the valid cycle; outputs are sampled 1 time unit after the rising fsys edge.
// Backpressure: not applicable; every wait is a fixed cycle budget.
module tb_clk_meas;

    logic        fsys;
    logic        rst;
    logic        clk_in;
    logic        start;

    logic        busy26, valid26, err26;
    logic [26:0] period26;
    logic [4:0]  s26;
    logic        busy4, valid4, err4;
    logic [4:0]  period4;
    logic [1:0]  s4;

    int checks = 0;
    int errors = 0;

    // Generator for the measured clock: a periodic waveform or a static level, updated on the falling fsys edge.
    bit gen_en  = 1'b0;
    bit gen_lvl = 1'b0;
    int gen_per = 2;
    int gen_hi  = 1;
    int gen_ph  = 0;

    clk_meas u26 (
        .fsys(fsys), .clk_meas_rst(rst), .clk_meas_in(clk_in), .clk_meas_start(start),
        .clk_meas_busy(busy26), .clk_meas_valid(valid26), .clk_meas_err(err26),
        .clk_meas_period(period26), .clk_meas_s(s26)
    );

    clk_meas #(.SIZE(4), .SYNC_STAGES(2)) u4 (
        .fsys(fsys), .clk_meas_rst(rst), .clk_meas_in(clk_in), .clk_meas_start(start),
        .clk_meas_busy(busy4), .clk_meas_valid(valid4), .clk_meas_err(err4),
        .clk_meas_period(period4), .clk_meas_s(s4)
    );

    initial begin
        fsys = 1'b0;
        forever #5 fsys = ~fsys;
    end

    initial begin
        clk_in = 1'b0;
        forever begin
            @(negedge fsys);
            if (gen_en) begin
                gen_ph = (gen_ph + 1) % gen_per;
                clk_in = (gen_ph < gen_hi);
            end else begin
                clk_in = gen_lvl;
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the result of measuring edges p cycles apart with a meter of the given SIZE.
    function automatic void model(input int size, input int p, output int ep, output int es, output int ee);
        int allones;
        int lg;
        allones = (1 << (size + 1)) - 1;
        if (p > allones) begin
            ep = allones;
            es = 0;
            ee = 1;
        end else begin
            lg = 0;
            while ((1 << (lg + 1)) <= p) lg++;
            ep = p;
            es = (lg > 0) ? lg - 1 : 0;
            ee = (((p & (p - 1)) != 0) || (p > (1 << size))) ? 1 : 0;
        end
    endfunction

    task automatic pulse_reset();
        @(posedge fsys); #1;
        rst = 1'b1;
        repeat (2) @(posedge fsys);
        #1 rst = 1'b0;
    endtask

    task automatic measure(input int per, input int hi,
                           input int ep26, input int es26, input int ee26,
                           input int ep4, input int es4, input int ee4);
        int n26, n4;
        longint gp26, gs26, ge26, gp4, gs4, ge4;
        n26 = 0; n4 = 0;
        gp26 = 0; gs26 = 0; ge26 = 0; gp4 = 0; gs4 = 0; ge4 = 0;
        @(posedge fsys); #1;
        gen_per = per; gen_hi = hi; gen_ph = 0; gen_en = 1'b1;
        repeat (per + 6 + $urandom_range(0, per)) @(posedge fsys);
        #1 start = 1'b1;
        chk("busy_before_start", busy26, 0);
        @(posedge fsys); #1 start = 1'b0;
        chk("busy_after_start26", busy26, 1);
        chk("busy_after_start4", busy4, 1);
        for (int k = 0; k < 3 * per + 80; k++) begin
            @(posedge fsys); #1;
            if (valid26) begin
                if (n26 == 0) begin gp26 = period26; gs26 = s26; ge26 = err26; end
                n26++;
            end
            if (valid4) begin
                if (n4 == 0) begin gp4 = period4; gs4 = s4; ge4 = err4; end
                n4++;
            end
        end
        chk("valid26_seen", (n26 > 0), 1);
        chk("period26", gp26, ep26);
        chk("s26", gs26, es26);
        chk("err26", ge26, ee26);
        chk("valid4_seen", (n4 > 0), 1);
        chk("period4", gp4, ep4);
        chk("s4", gs4, es4);
        chk("err4", ge4, ee4);
`ifndef CLK_MEAS_CONT_EN
        chk("valid26_count", n26, 1);
        chk("valid4_count", n4, 1);
        chk("busy26_after", busy26, 0);
        chk("busy4_after", busy4, 0);
`else
        pulse_reset();
`endif
    endtask

    typedef struct {
        int per;
        int hi;
        int p26, s26, e26;
        int p4, s4, e4;
    } vec_t;

    initial begin
        vec_t vecs[8];
        int   n;
        int   ep26, es26, ee26, ep4, es4, ee4;

        rst = 1'b1;
        start = 1'b0;

        // Reset values, checked while reset is held and after it is released.
        repeat (2) @(posedge fsys);
        #1;
        chk("rst_busy", busy26, 0);
        chk("rst_valid", valid26, 0);
        chk("rst_err", err26, 0);
        chk("rst_period", period26, 0);
        chk("rst_s", s26, 0);
        chk("rst_period4", period4, 0);
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge fsys); #1;
            if (valid26 || valid4 || busy26 || busy4) n++;
        end
        chk("idle_no_activity", n, 0);

        vecs[0] = '{16, 8, 16, 3, 0, 16, 3, 0};
        vecs[1] = '{2,  1, 2,  0, 0, 2,  0, 0};
        vecs[2] = '{7,  3, 7,  1, 1, 7,  1, 1};
        vecs[3] = '{4,  1, 4,  1, 0, 4,  1, 0};
        vecs[4] = '{24, 5, 24, 3, 1, 24, 3, 1};
        vecs[5] = '{17, 9, 17, 3, 1, 17, 3, 1};
        vecs[6] = '{32, 16, 32, 4, 0, 31, 0, 1};
        vecs[7] = '{8,  6, 8,  2, 0, 8,  2, 0};
        foreach (vecs[i])
            measure(vecs[i].per, vecs[i].hi, vecs[i].p26, vecs[i].s26, vecs[i].e26,
                    vecs[i].p4, vecs[i].s4, vecs[i].e4);

        // Random periods and duty cycles checked against the reference model.
        for (int it = 0; it < 20; it++) begin
            int per, hi;
            per = $urandom_range(2, 40);
            hi  = $urandom_range(1, per - 1);
            model(26, per, ep26, es26, ee26);
            model(4, per, ep4, es4, ee4);
            measure(per, hi, ep26, es26, ee26, ep4, es4, ee4);
        end

        // Timeout: arm on a single edge, then hold the input high so that the SIZE=4 counter saturates.
        @(posedge fsys); #1;
        gen_en = 1'b0; gen_lvl = 1'b0;
        repeat (10) @(posedge fsys);
        #1 start = 1'b1;
        @(posedge fsys); #1 start = 1'b0;
        repeat (3) @(posedge fsys);
        #1 gen_lvl = 1'b1;
        begin
            int nv;
            longint tp, ts, te;
            nv = 0; tp = 0; ts = 0; te = 0;
            for (int k = 0; k < 60; k++) begin
                @(posedge fsys); #1;
                if (valid4) begin
                    if (nv == 0) begin tp = period4; ts = s4; te = err4; end
                    nv++;
                end
            end
            chk("tmo_valid_count", nv, 1);
            chk("tmo_period", tp, 31);
            chk("tmo_s", ts, 0);
            chk("tmo_err", te, 1);
            chk("tmo_idle", busy4, 0);
            chk("tmo_big_still_counting", busy26, 1);
        end

        // Reset in the middle of a count takes effect immediately and leaves no pulse behind.
        @(posedge fsys); #1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy26, 0);
        chk("midrst_valid", valid26, 0);
        repeat (2) @(posedge fsys);
        #1 rst = 1'b0;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge fsys); #1;
            if (valid26 || valid4) n++;
        end
        chk("midrst_no_pulse", n, 0);
        chk("midrst_idle", busy26, 0);

`ifdef CLK_MEAS_CONT_EN
        // Continuous mode: a single start gives a valid every input period.
        begin
            int nv, last_t, t;
            @(posedge fsys); #1;
            gen_per = 8; gen_hi = 4; gen_ph = 0; gen_en = 1'b1;
            repeat (20) @(posedge fsys);
            #1 start = 1'b1;
            @(posedge fsys); #1 start = 1'b0;
            nv = 0; last_t = 0; t = 0;
            for (int k = 0; k < 200 && nv < 6; k++) begin
                @(posedge fsys); #1;
                t++;
                if (valid26) begin
                    chk("cont_period", period26, 8);
                    chk("cont_err", err26, 0);
                    if (nv > 0) chk("cont_spacing", t - last_t, 8);
                    last_t = t;
                    nv++;
                end
            end
            chk("cont_valid_count", nv, 6);
            chk("cont_busy", busy26, 1);
            @(posedge fsys); #1;
            rst = 1'b1;
            #1;
            chk("cont_rst_busy", busy26, 0);
            chk("cont_rst_valid", valid26, 0);
            repeat (2) @(posedge fsys);
            #1 rst = 1'b0;
            n = 0;
            for (int k = 0; k < 100; k++) begin
                @(posedge fsys); #1;
                if (valid26 || valid4 || busy26) n++;
            end
            chk("cont_rst_quiet", n, 0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_meas.md
# clk_meas

Clock-period meter that sits on the receiving end of `clk_gen`: it samples a slow divided clock (e.g. `clk_gen_out`) in the `fsys` domain, counts `fsys` cycles between two consecutive rising edges, and reports the period together with the divider select that would have produced it. It is used in-system and on the bench to confirm that the clock generator's select setting matches the divided clock actually delivered.

## Interface
- `SIZE`, 26: divider span of the measured generator; legal selects are 0..SIZE-1, so the period is 2^(s+1).
- `SYNC_STAGES`, 2: input synchronizer depth, minimum 2.

- `fsys` in 1: system clock; all logic is on its rising edge.
- `clk_meas_rst` in 1: reset, asynchronous and active-high.
- `clk_meas_in` in 1: clock under measurement, treated as asynchronous.
- `clk_meas_start` in 1: single-cycle request to begin a measurement.
- `clk_meas_busy` out 1: high while in ARM or COUNT.
- `clk_meas_valid` out 1: one-cycle pulse when new results are presented.
- `clk_meas_err` out 1: qualifies the latest result as bad; held with the results.
- `clk_meas_period` out SIZE+1: measured period in `fsys` cycles.
- `clk_meas_s` out $clog2(SIZE): derived divider select.

## Operation
- The input passes through a synchronizer of SYNC_STAGES flops, then one delay flop. `rise = sync & ~sync_d`.
- The FSM has three states: IDLE, ARM and COUNT. The counter `cnt` is SIZE+1 bits wide.
- **IDLE:** `clk_meas_start` moves the FSM to ARM. Start is ignored in ARM and COUNT.
- **ARM:** on `rise`, set `cnt <= 1` and go to COUNT.
- **COUNT, no `rise`:** `cnt <= cnt + 1`.
- **COUNT, `rise`:**
  - Capture the results and pulse valid.
  - `period <= cnt`.
  - `s <= log2(cnt) - 1`.
  - `err <= 1` if `cnt` is not a power of two or `cnt > 2^SIZE`.
  - The next state is set by the macro (see Configuration).
- **Timeout:** in COUNT, `cnt` reaching all-ones without a `rise` is a timeout. Set `period <= all-ones`, `s <= 0`, `err <= 1`, pulse valid, and go to IDLE. This rule applies in both modes.
- **Output hold:** `period`, `s` and `err` hold until the next capture.
- **`rise` and start in the same cycle:** if `rise` occurs in the IDLE cycle that accepts start, that edge is not used. Measurement uses the next `rise` seen in ARM.

## Timing
- **Reset values:** state IDLE, `busy=0`, `valid=0`, `err=0`, `period=0`, `s=0`, `cnt=0`, all synchronizer flops 0.
- **Mid-operation reset:** reset in ARM or COUNT returns the FSM to IDLE immediately. No valid pulse is produced.
- **Start to busy:** `busy` rises the cycle after start is accepted.
- **Edge latency:** from a `clk_meas_in` rising edge to its `rise` pulse is SYNC_STAGES+1 `fsys` cycles.
- **Result latency:** results and `valid=1` appear in the cycle after the closing `rise`.
- **Measured period:** rising edges P `fsys` cycles apart give `period = P`.
  - Minimum P is 2, giving `s = 0`.
  - Maximum valid P is 2^SIZE, giving `s = SIZE-1`.
- **`busy` timing:** `busy` falls in the same cycle `valid` pulses in single-shot mode.

## Configuration
- `CLK_MEAS_CONT_EN` defined (continuous mode):
  - On a capturing `rise`, the FSM stays in COUNT with `cnt <= 1`.
  - The closing edge becomes the opening edge of the next measurement.
  - `valid` pulses once per input period until reset or timeout.
  - `clk_meas_start` is needed only to leave IDLE.
- `CLK_MEAS_CONT_EN` undefined (single-shot mode): a capture returns the FSM to IDLE, and each measurement needs a new start.

## Test plan
- **Reset values:** hold reset 2 cycles, then release. Required: all outputs 0, FSM in IDLE, and no `valid` for 100 cycles without start.
- **Select s=3:** drive `clk_gen` (SIZE=26) into `clk_meas_in` and pulse start. Required: `period=16`, `s=3`, `err=0`, `valid` high exactly 1 cycle, `busy` then 0.
- **Extremes, SIZE=4:** s=0 must give `period=2`, `s=0`. s=3 must give `period=16`, `s=3`. Both with `err=0`.
- **Non-power-of-two:** input high 3 cycles, low 4 cycles (P=7). Required: `period=7`, `err=1`.
- **Timeout, SIZE=4:** hold the input static after arming. Required: `valid` with `period=31` and `err=1` after the counter saturates, then IDLE.
- **Continuous mode and reset, `CLK_MEAS_CONT_EN`:** with s=2, one start must yield a `valid` every 8 cycles with `period=8`. Asserting reset mid-count must drop `busy` and `valid` immediately, with no spurious pulse after release.
